div_arbiter: RTL and testbench

- Shares one `divisor_restoring` instance between N_REQ requesters.
- Round-robin arbitration picks a requester, latches its operands and pulses the divider's `start`. The block then waits for `done`, returns Q/R tagged with the requester id, and releases the divider.
- Divide-by-zero is handled without using the divider. A watchdog guards against a divider that never finishes.
- Sits between the top-level operand sources (switch/keypad decoders) and the divider. The divider's ports connect 1:1 to the `div_*` ports.

---
 rtl/div_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/div_arbiter.sv | 173 +++++++++++++++++
 tb/tb_div_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared types for the divider arbiter: FSM state encoding and response error codes.
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } div_arb_state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_any
);
  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] w_pos;
  logic          w_hit;

  // Scan requesters starting at the pointer; the first hit wins
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    w_hit   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos          = IW'((int'(i_ptr) + k) % N_REQ);
      w_hit          = i_req[w_pos] & ~o_any;
      o_grant[w_pos] = o_grant[w_pos] | w_hit;
      o_idx          = w_hit ? w_pos : o_idx;
      o_any          = o_any | w_hit;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one restoring divider among N_REQ requesters: round-robin grant, operand
// latch, start/done handshake, divide-by-zero bypass and a WAIT-state watchdog.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = 7,
  parameter int TIMEOUT = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*W-1:0]         req_a,
  input  logic [N_REQ*W-1:0]         req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [W-1:0]               rsp_q,
  output logic [W-1:0]               rsp_r,
  output logic [1:0]                 rsp_err,
  output logic                       busy,
  output logic                       div_start,
  output logic [W-1:0]               div_a,
  output logic [W-1:0]               div_b,
  input  logic [W-1:0]               div_q,
  input  logic [W-1:0]               div_r,
  input  logic                       div_done
);
  localparam int IW  = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  div_arb_state_t r_state;
  div_arb_state_t w_next_state;
  logic [IW-1:0]  r_ptr;
  logic [IW-1:0]  r_id;
  logic [WDW-1:0] r_wd;

  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;
  logic             w_take;
  logic             w_issue;
  logic             w_rsp_load;
  logic [IW-1:0]    w_rsp_id;
  logic [W-1:0]     w_rsp_q;
  logic [W-1:0]     w_rsp_r;
  logic [1:0]       w_rsp_err;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_sel_a = req_a[int'(w_idx) * W +: W];
  assign w_sel_b = req_b[int'(w_idx) * W +: W];

  // Next-state and response selection
  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    w_issue      = 1'b0;
    w_rsp_load   = 1'b0;
    w_rsp_id     = r_id;
    w_rsp_q      = '0;
    w_rsp_r      = '0;
    w_rsp_err    = ERR_OK;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_take = 1'b1;
          if (w_sel_b == '0) begin
            w_next_state = RESP;
            w_rsp_load   = 1'b1;
            w_rsp_id     = w_idx;
            w_rsp_q      = '1;
            w_rsp_r      = w_sel_a;
            w_rsp_err    = ERR_DIV0;
          end else begin
            w_next_state = ISSUE;
            w_issue      = 1'b1;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      ISSUE: begin
        w_next_state = WAIT;
      end
      WAIT: begin
        // r_wd == 0 is the first WAIT cycle: a done still high from the last op is not trusted
        if ((r_wd != '0) && div_done) begin
          w_next_state = RESP;
          w_rsp_load   = 1'b1;
          w_rsp_q      = div_q;
          w_rsp_r      = div_r;
          w_rsp_err    = ERR_OK;
        end else if (r_wd == WDW'(TIMEOUT - 1)) begin
          w_next_state = RESP;
          w_rsp_load   = 1'b1;
          w_rsp_err    = ERR_TIMEOUT;
        end else begin
          w_next_state = WAIT;
        end
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Pointer, watchdog, operand latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_wd      <= '0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_err   <= ERR_OK;
      busy      <= 1'b0;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
    end else begin
      req_ready <= w_take ? w_grant : '0;
      div_start <= w_issue;
      rsp_valid <= w_rsp_load;
      busy      <= (w_next_state != IDLE);
      if (w_take) begin
        r_ptr <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + IW'(1);
        r_id  <= w_idx;
      end
      if (w_issue) begin
        div_a <= w_sel_a;
        div_b <= w_sel_b;
      end
      if (r_state == ISSUE) begin
        r_wd <= '0;
      end else if (r_state == WAIT) begin
        r_wd <= r_wd + WDW'(1);
      end
      if (w_rsp_load) begin
        rsp_id  <= w_rsp_id;
        rsp_q   <= w_rsp_q;
        rsp_r   <= w_rsp_r;
        rsp_err <= w_rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural divider model (normal, never-done, sticky-done).
module tb_div_arbiter;
  localparam int N       = 4;
  localparam int W       = 7;
  localparam int TO      = 32;
  localparam int DIV_LAT = 9;
  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_STICKY = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_q;
  logic [W-1:0]   rsp_r;
  logic [1:0]     rsp_err;
  logic           busy;
  logic           div_start;
  logic [W-1:0]   div_a;
  logic [W-1:0]   div_b;
  logic [W-1:0]   div_q;
  logic [W-1:0]   div_r;
  logic           div_done;

  always #5 clk = ~clk;

  div_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q),
    .rsp_r(rsp_r), .rsp_err(rsp_err), .busy(busy), .div_start(div_start),
    .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r), .div_done(div_done)
  );

  typedef struct {
    int id; int a; int b; int q; int r; int err;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_q[$];

  // driver-owned model state
  int   mptr;
  bit   pend[N];
  int   pa[N];
  int   pb[N];
  int   dmode;
  int   drv_timeouts;
  bit   tb_done;

  // monitor-owned state
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_start = 0;
  int start_at_grant = 0;
  int grant_cyc = 0;
  int start_cyc = 0;
  bit prev_start = 1'b0;
  bit prev_rsp = 1'b0;
  bit rst_chk = 1'b0;

  // Divider model: result DIV_LAT cycles after start; mode selects done behaviour
  logic [W-1:0] m_a, m_b;
  int           m_cnt;
  bit           m_drop;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0; m_drop <= 1'b0; div_done <= 1'b0; div_q <= '0; div_r <= '0;
      m_a <= '0; m_b <= '0;
    end else begin
      m_drop <= 1'b0;
      if (m_drop) div_done <= 1'b0;
      if (div_start) begin
        m_a <= div_a; m_b <= div_b; m_cnt <= DIV_LAT;
        if (dmode == M_STICKY) m_drop <= 1'b1;
        else div_done <= 1'b0;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1 && dmode != M_NEVER) begin
          div_done <= 1'b1; div_q <= m_a / m_b; div_r <= m_a % m_b;
        end
      end else if (dmode == M_NORMAL) begin
        div_done <= 1'b0;
      end
    end
  end

  function automatic bit any_pend();
    bit v = 1'b0;
    for (int i = 0; i < N; i++) v = v | pend[i];
    return v;
  endfunction

  task automatic post(input int id, input int a, input int b);
    req_valid[id] = 1'b1;
    req_a[id*W +: W] = W'(a);
    req_b[id*W +: W] = W'(b);
    pend[id] = 1'b1; pa[id] = a; pb[id] = b;
  endtask

  // Advance one cycle; on a grant, predict the winner from the bench's own round-robin view
  task automatic tick();
    int g;
    exp_t e;
    @(negedge clk);
    if (req_ready != '0) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
      gnt_q.push_back(g);
      if (g >= 0) begin
        e.id = g; e.a = pa[g]; e.b = pb[g];
        if (pb[g] == 0) begin
          e.q = (1 << W) - 1; e.r = pa[g]; e.err = 1;
        end else if (dmode == M_NEVER) begin
          e.q = 0; e.r = 0; e.err = 2;
        end else begin
          e.q = pa[g] / pb[g]; e.r = pa[g] % pb[g]; e.err = 0;
        end
        exp_q.push_back(e);
        req_valid[g] = 1'b0; pend[g] = 1'b0; mptr = (g + 1) % N;
      end
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    do begin
      tick(); n++;
    end while ((exp_q.size() != 0 || busy || any_pend()) && n < max_cyc);
    if (exp_q.size() != 0 || busy || any_pend()) drv_timeouts++;
  endtask

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or a response
  always @(negedge clk) begin
    exp_t e;
    int g;
    #1;
    cyc++;
    if (rst) begin
      exp_q.delete(); gnt_q.delete();
      rst_chk = 1'b1; prev_start = 1'b0; prev_rsp = 1'b0;
    end else begin
      if (rst_chk) begin
        rst_chk = 1'b0;
        chk("reset_outputs", longint'({req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
                                        busy, div_start, div_a, div_b}), 0);
      end
      if (prev_rsp) chk("busy_after_rsp", longint'(busy), 0);
      if (req_ready != '0) begin
        g = (gnt_q.size() != 0) ? gnt_q.pop_front() : -1;
        chk("grant", longint'(req_ready), (g >= 0) ? longint'(1 << g) : 0);
        grant_cyc = cyc; start_at_grant = n_start;
      end
      if (div_start) begin
        chk("start_pulse", longint'(prev_start), 0);
        n_start++; start_cyc = cyc;
        chk("start_has_op", longint'(exp_q.size()), 1);
        if (exp_q.size() != 0) begin
          chk("div_a", longint'(div_a), exp_q[0].a);
          chk("div_b", longint'(div_b), exp_q[0].b);
        end
      end
      if (rsp_valid) begin
        chk("rsp_pulse", longint'(prev_rsp), 0);
        chk("rsp_expected", longint'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_id", longint'(rsp_id), e.id);
          chk("rsp_q", longint'(rsp_q), e.q);
          chk("rsp_r", longint'(rsp_r), e.r);
          chk("rsp_err", longint'(rsp_err), e.err);
          case (e.err)
            1: begin
              chk("div0_latency", cyc - grant_cyc, 0);
              chk("div0_no_start", n_start - start_at_grant, 0);
            end
            2: chk("timeout_latency", cyc - start_cyc, TO + 1);
            default: begin
              chk("op_latency", cyc - grant_cyc, DIV_LAT + 2);
              chk("op_one_start", n_start - start_at_grant, 1);
            end
          endcase
        end
      end
      prev_start = div_start;
      prev_rsp = rsp_valid;
    end
    if (tb_done) begin
      chk("queue_drained", exp_q.size(), 0);
      chk("driver_timeouts", drv_timeouts, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    int n, ra, rb, v;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    dmode = M_NORMAL; mptr = 0; drv_timeouts = 0; tb_done = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pa[i] = 0; pb[i] = 0; end
    repeat (3) tick();
    rst = 1'b0;

    // all four at once: grants 0,1,2,3
    post(0, 85, 5); post(1, 64, 8); post(2, 123, 9); post(3, 100, 13);
    wait_idle(200);

    post(0, 127, 7);
    wait_idle(60);

    post(2, 99, 0);
    wait_idle(60);

    // divider that never finishes, then recovery
    dmode = M_NEVER;
    post(1, 50, 3);
    wait_idle(TO + 40);
    dmode = M_NORMAL;
    post(0, 99, 10);
    wait_idle(60);

    // done held high into the next op
    dmode = M_STICKY;
    post(1, 127, 7);
    wait_idle(60);
    post(1, 64, 8);
    wait_idle(60);
    dmode = M_NORMAL;
    tick();

    // reset while in WAIT abandons the op
    post(0, 100, 3);
    n = 0;
    while (!div_start && n < 50) begin tick(); n++; end
    if (!div_start) drv_timeouts++;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; mptr = 0;
    post(3, 85, 5);
    wait_idle(60);

    // random traffic with occasional withdrawals
    for (int it = 0; it < 120; it++) begin
      for (int id = 0; id < N; id++) begin
        if (!pend[id] && $urandom_range(0, 3) == 0) begin
          ra = int'($urandom_range(0, 127));
          rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
          post(id, ra, rb);
        end
      end
      tick();
      if ($urandom_range(0, 9) == 0) begin
        v = int'($urandom_range(0, N - 1));
        if (pend[v]) begin req_valid[v] = 1'b0; pend[v] = 1'b0; end
      end
    end
    wait_idle(3000);

    tb_done = 1'b1;
    repeat (20) @(negedge clk);
    $display("FAIL tb_end monitor did not reach summary");
    $fatal(1, "bench did not terminate");
  end

endmodule
